// File: rtl/fp8_pkg.sv
// fp8_pkg: shared FP8 (E4M3) definitions and the multiplier-arbiter state type.
package fp8_pkg;

  // E4M3 field layout: 1 sign bit, 4 exponent bits, 3 mantissa bits.
  localparam int EXP_W = 4;
  localparam int MAN_W = 3;
  localparam int BIAS  = 7;

  // Reference encodings.
  localparam logic [7:0] FP8_NAN  = 8'hFF;
  localparam logic [7:0] FP8_ZERO = 8'h00;
  localparam logic [7:0] FP8_ONE  = 8'h38;

  // Arbiter sequencing states.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,  // arbitrating among valid requesters
    ST_ISSUE   = 2'd1,  // start held high, waiting for done
    ST_RELEASE = 2'd2   // start low, waiting for done to fall
  } arb_state_e;

endpackage

// File: rtl/fp8_mul_arbiter_rr_pick.sv
// rr_pick: combinational round-robin priority selector.
// Finds the first set request bit at or above ptr, wrapping from NUM_REQ-1
// back to 0, and returns it both one-hot and as an index.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    idx,
  output logic               any
);

  // Rotating priority search starting at the pointer.
  always_comb begin
    // NOTE: every output gets a default before the search so no path through
    // the loop leaves a value unassigned, which would infer a latch.
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      int cand;
      cand = (int'(ptr) + k) % NUM_REQ;
      if (!any && req[cand]) begin
        grant[cand] = 1'b1;
        idx         = ID_W'(cand);
        any         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fp8_mul_arbiter.sv
// fp8_mul_arbiter: round-robin sequencer that shares one FP8 E4M3 multiplier
// among NUM_REQ requesters using the multiplier's four-phase start/done
// handshake, and routes each product back to its requester.
// Optional build macro FP8_MUL_ARB_TIMEOUT_EN adds a watchdog on both done
// waits and the rsp_err output flagging a timed-out operation.
module fp8_mul_arbiter
  import fp8_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int ID_W           = $clog2(NUM_REQ),
  parameter int TIMEOUT_CYCLES = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_a,
  input  logic [8*NUM_REQ-1:0] req_b,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [NUM_REQ-1:0]   rsp_valid,
  output logic [ID_W-1:0]      rsp_id,
  output logic [7:0]           rsp_product,
`ifdef FP8_MUL_ARB_TIMEOUT_EN
  output logic                 rsp_err,
`endif
  output logic                 mul_start,
  output logic [7:0]           mul_a,
  output logic [7:0]           mul_b,
  input  logic                 mul_done,
  input  logic [7:0]           mul_product
);

  // Reject parameter sets the index and watchdog logic are not built for.
  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("fp8_mul_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES >= 1");
  end

  arb_state_e          state_q;
  arb_state_e          state_d;
  logic [ID_W-1:0]     ptr_q;      // highest-priority requester for next pick
  logic [ID_W-1:0]     gid_q;      // requester owning the operation in flight
  logic [NUM_REQ-1:0]  pick_grant;
  logic [ID_W-1:0]     pick_idx;
  logic                pick_any;
  logic [ID_W-1:0]     ptr_next;
  logic                wdog_expired;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .req   (req_valid),
    .ptr   (ptr_q),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // Pointer moves to just past the winner, wrapping at NUM_REQ-1.
  assign ptr_next = (pick_idx == ID_W'(NUM_REQ - 1)) ? '0 : pick_idx + ID_W'(1);

`ifdef FP8_MUL_ARB_TIMEOUT_EN
  localparam int WDOG_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WDOG_W-1:0] wdog_q;

  // Watchdog: counts cycles spent in ISSUE or RELEASE, cleared on every
  // state change so each wait gets its own full budget.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wdog_q <= '0;
    end else if (state_d != state_q) begin
      wdog_q <= '0;
    end else if (state_q != ST_IDLE) begin
      wdog_q <= wdog_q + WDOG_W'(1);
    end
  end

  // Counter value T-1 is sampled at the T-th edge after start rose.
  assign wdog_expired = (wdog_q == WDOG_W'(TIMEOUT_CYCLES - 1));
`else
  assign wdog_expired = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of block evaluation order.
      state_q <= state_d;
    end
  end

  // Next-state logic: a new start is only possible from IDLE, and IDLE is
  // only re-entered once done has fallen, so start never rises over done.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (pick_any)                  state_d = ST_ISSUE;
      ST_ISSUE:   if (mul_done || wdog_expired)  state_d = ST_RELEASE;
      ST_RELEASE: if (!mul_done || wdog_expired) state_d = ST_IDLE;
      default:                                   state_d = ST_IDLE;
    endcase
  end

  // Registered outputs and datapath; ready/valid(/err) are one-cycle pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q       <= '0;
      gid_q       <= '0;
      req_ready   <= '0;
      rsp_valid   <= '0;
      rsp_id      <= '0;
      rsp_product <= '0;
      mul_start   <= 1'b0;
      mul_a       <= '0;
      mul_b       <= '0;
`ifdef FP8_MUL_ARB_TIMEOUT_EN
      rsp_err     <= 1'b0;
`endif
    end else begin
      req_ready <= '0;
      rsp_valid <= '0;
`ifdef FP8_MUL_ARB_TIMEOUT_EN
      rsp_err   <= 1'b0;
`endif
      unique case (state_q)
        ST_IDLE: begin
          if (pick_any) begin
            mul_a     <= req_a[{pick_idx, 3'b000} +: 8];
            mul_b     <= req_b[{pick_idx, 3'b000} +: 8];
            gid_q     <= pick_idx;
            ptr_q     <= ptr_next;
            mul_start <= 1'b1;
            req_ready <= pick_grant;
          end
        end
        ST_ISSUE: begin
          if (mul_done) begin
            rsp_product <= mul_product;
            rsp_id      <= gid_q;
            rsp_valid   <= NUM_REQ'(1) << gid_q;
            mul_start   <= 1'b0;
          end
`ifdef FP8_MUL_ARB_TIMEOUT_EN
          else if (wdog_expired) begin
            // Multiplier never answered: return NaN and flag the error.
            rsp_product <= FP8_NAN;
            rsp_id      <= gid_q;
            rsp_valid   <= NUM_REQ'(1) << gid_q;
            rsp_err     <= 1'b1;
            mul_start   <= 1'b0;
          end
`endif
        end
        default: begin
          mul_start <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/fp8_mul_arbiter.md
Name: fp8_mul_arbiter

Overview:
- Round-robin arbiter/sequencer that shares one FP8 (E4M3, bias 7) multiplier among NUM_REQ requesters.
- Accepts operand pairs from requesters and drives the multiplier's start/done four-phase handshake.
- Routes each product back to the requester it belongs to.
- Sits between the MAC lanes and the single multiplier instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, $clog2(NUM_REQ), requester index width.
- TIMEOUT_CYCLES, 32, watchdog limit on the wait for mul_done (used only with the optional feature).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester operand-pair valid.
- req_a  in  8*NUM_REQ  operand A, requester i at [8i+7:8i].
- req_b  in  8*NUM_REQ  operand B, same packing.
- req_ready  out  NUM_REQ  one-hot acceptance pulse.
- rsp_valid  out  NUM_REQ  one-hot result pulse.
- rsp_id  out  ID_W  index of the requester being answered.
- rsp_product  out  8  shared result bus.
- mul_start  out  1  multiplier start level.
- mul_a  out  8  multiplier operand A.
- mul_b  out  8  multiplier operand B.
- mul_done  in  1  multiplier done level.
- mul_product  in  8  multiplier result.

Behaviour:
- Reset (async, rst=1) values:
  - All outputs 0: req_ready, rsp_valid, rsp_id, rsp_product, mul_start, mul_a, mul_b.
  - State=IDLE, round-robin pointer=0, watchdog counter=0.
  - Reset mid-operation abandons the operation with no response. The system resets the multiplier in the same cycle.
- Requester rule: hold req_valid and operands stable until req_ready is seen high. The transfer completes in that cycle. Dropping valid earlier is illegal.
- States: IDLE, ISSUE, RELEASE. All outputs are registered.
- IDLE:
  - Each cycle, pick the first i with req_valid[i]=1, searching from the pointer upward and wrapping at NUM_REQ-1 -> 0.
  - If a requester is found: latch mul_a/mul_b from requester i and record grant id g=i.
  - Next cycle: mul_start=1, req_ready[g]=1 for exactly one cycle, pointer=(g+1) mod NUM_REQ, state=ISSUE.
  - If none valid: stay in IDLE, pointer unchanged.
- ISSUE:
  - Hold mul_start=1 and mul_a/mul_b stable.
  - On sampling mul_done=1:
    - rsp_product<=mul_product.
    - rsp_id<=g.
    - rsp_valid[g]<=1 for exactly one cycle.
    - mul_start<=0.
    - state=RELEASE.
- RELEASE:
  - mul_start=0. Wait for mul_done=0, then go to IDLE.
  - Arbitration resumes only in IDLE, so the multiplier always sees start low before the next start rises.
- Requests arriving during ISSUE/RELEASE are held by the requester and ignored by the arbiter until IDLE.
- Latency depends on the multiplier.
  - Multiplier done-to-deassert cost is 2 cycles, so the arbiter adds ~4 cycles per op: 1 IDLE, 1 start-registration, 1 done-capture, ≥1 RELEASE.
  - Any multiplier latency is tolerated; the arbiter never assumes a fixed count.
- Fairness: with all requesters continuously valid, grant order is 0,1,2,...,NUM_REQ-1,0,...
- A requester with a single valid request waits at most NUM_REQ-1 other operations.
- Products are passed through unmodified; the arbiter does no arithmetic on them.

Optional Feature:
- Macro: FP8_MUL_ARB_TIMEOUT_EN.
- With the macro:
  - A counter runs in ISSUE.
  - If mul_done is not seen within TIMEOUT_CYCLES cycles, the arbiter responds to g with rsp_product=0xFF (NaN), pulses output rsp_err for one cycle alongside rsp_valid, drops mul_start, and enters RELEASE.
  - Port rsp_err (out, 1, reset 0) exists.
  - In RELEASE, a second TIMEOUT_CYCLES-cycle wait for mul_done=0 also forces return to IDLE.
- Without the macro: no counter and no rsp_err port; the arbiter waits indefinitely.

Decomposition:
- Shared package fp8_pkg holds:
  - FP8 field widths (EXP_W=4, MAN_W=3) and BIAS=7.
  - Encodings FP8_NAN=8'hFF, FP8_ZERO=8'h00, FP8_ONE=8'h38.
  - The arbiter state enum.
- One natural sub-module: rr_pick, a combinational round-robin priority selector (request vector + pointer -> one-hot grant + index + any).

Test Plan:
- Single request: req0 valid with a=0x3C, b=0x3C, multiplier model behaves like the team FP8 multiplier -> req_ready[0] once, rsp_valid[0] once, rsp_id=0, rsp_product=0x41.
- All four valid continuously, each with a=0x38, b=0x40 -> grants in order 0,1,2,3,0; each rsp_product=0x40; mul_start never rises while mul_done=1.
- Specials:
  - req2 a=0x7F, b=0x38 -> rsp_product=0xFF, rsp_id=2.
  - req1 a=0x00, b=0x38 -> rsp_product=0x00.
- Pointer wrap: pointer=3 after serving req2, req0 and req3 valid -> req3 granted first, then req0.
- Reset mid-ISSUE: assert rst while mul_start=1 -> all outputs 0 immediately; after release, req1 is granted first from pointer 0 and the stale response is never emitted.
- FP8_MUL_ARB_TIMEOUT_EN, mul_done stuck 0 -> exactly TIMEOUT_CYCLES cycles after mul_start rises: rsp_valid[g]=1, rsp_err=1, rsp_product=0xFF, then return to IDLE.
